// File: rtl/fifo.sv
// Standard synchronous fifo: 2^DEPTH_WIDTH entries, write ignored when full,
// read data registered and valid the cycle after rd_en_i && !empty_o.
module fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  full_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  empty_o
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [DEPTH_WIDTH:0]  wr_ptr;
    logic [DEPTH_WIDTH:0]  rd_ptr;
    logic                  wr_fire;
    logic                  rd_fire;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[DEPTH_WIDTH] != rd_ptr[DEPTH_WIDTH]) &&
                     (wr_ptr[DEPTH_WIDTH-1:0] == rd_ptr[DEPTH_WIDTH-1:0]);
    assign wr_fire = wr_en_i && !full_o;
    assign rd_fire = rd_en_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_data_o <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr    <= rd_ptr + 1'b1;
                rd_data_o <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[DEPTH_WIDTH-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fifo_stream_wr.sv
// Valid/ready stream into a standard fifo through a 2-entry skid stage.
// Handshake: a word transfers on any edge where s_valid && s_ready; s_ready depends only on registers.
module fifo_stream_wr #(
    parameter int DATA_WIDTH         = 8,
    parameter int DEPTH_WIDTH        = 2,
    parameter int ALMOST_FULL_THRESH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   empty,
    output logic                   almost_full,
    output logic [DEPTH_WIDTH+1:0] cnt
);

    localparam int CNT_W = DEPTH_WIDTH + 2;

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  fifo_full;
    logic                  accept;
    logic                  drain;
    logic                  rd_fire;

    assign s_ready     = !skid_valid;
    assign accept      = s_valid && s_ready;
    assign drain       = out_valid && !fifo_full;
    assign rd_fire     = rd_en && !empty;
    assign almost_full = (cnt >= CNT_W'(ALMOST_FULL_THRESH));

    // Skid always refills the out stage before new input so order is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || drain) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data  <= s_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= s_data;
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            unique case ({accept, rd_fire})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_WIDTH(DEPTH_WIDTH)
    ) fifo0 (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (drain),
        .wr_data_i(out_data),
        .full_o   (fifo_full),
        .rd_en_i  (rd_en),
        .rd_data_o(dout),
        .empty_o  (empty)
    );

endmodule

// File: tb/tb_fifo_stream_wr.sv
// Directed and random checks of fifo_stream_wr against a reference occupancy queue.
module tb_fifo_stream_wr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       rd_en = 1'b0;
    logic [7:0] dout;
    logic       empty;
    logic       almost_full;
    logic [3:0] cnt;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd_log[$];
    logic [7:0] last_read = '0;

    fifo_stream_wr #(
        .DATA_WIDTH        (8),
        .DEPTH_WIDTH       (2),
        .ALMOST_FULL_THRESH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .rd_en      (rd_en),
        .dout       (dout),
        .empty      (empty),
        .almost_full(almost_full),
        .cnt        (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model the handshake from pre-edge values, then check #1 after the edge.
    task automatic cycle(output bit acc);
        bit rd;
        logic [7:0] e;
        e = '0;
        acc = s_valid && s_ready;
        rd = rd_en && !empty;
        if (acc) exp_q.push_back(s_data);
        if (rd) e = exp_q.pop_front();
        @(posedge clk);
        #1;
        if (rd) begin
            chk("dout_order", 32'(dout), 32'(e));
            rd_log.push_back(dout);
            last_read = e;
        end
        chk("cnt_model", 32'(cnt), 32'(exp_q.size()));
        chk("af_model", 32'(almost_full), 32'(exp_q.size() >= 4));
        chk("cnt_max", 32'(cnt <= 4'd6), 32'd1);
    endtask

    initial begin
        bit acc;
        int w;
        int n_acc;

        // 1: reset, idle, then asynchronous reset mid-cycle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        repeat (2) cycle(acc);
        chk("idle_cnt", 32'(cnt), 32'd0);
        s_data = 8'h5A; s_valid = 1'b1;
        cycle(acc);
        s_valid = 1'b0;
        cycle(acc);
        chk("pre_arst_empty", 32'(empty), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_cnt", 32'(cnt), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_s_ready", 32'(s_ready), 32'd1);
        #1 rst = 1'b0;
        exp_q.delete();

        // 2: single word latency and read
        s_data = 8'hA5; s_valid = 1'b1;
        cycle(acc);
        chk("single_acc", 32'(acc), 32'd1);
        chk("single_empty_n", 32'(empty), 32'd1);
        s_valid = 1'b0;
        cycle(acc);
        chk("single_empty_n1", 32'(empty), 32'd0);
        chk("single_cnt", 32'(cnt), 32'd1);
        rd_en = 1'b1;
        cycle(acc);
        rd_en = 1'b0;
        chk("single_dout", 32'(dout), 32'hA5);
        chk("single_cnt0", 32'(cnt), 32'd0);
        chk("single_empty", 32'(empty), 32'd1);

        // 3: fill with backpressure
        w = 1; n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            s_data = 8'(w); s_valid = (w <= 8);
            cycle(acc);
            if (acc) begin
                n_acc++;
                if (n_acc == 3) chk("fill_af_at3", 32'(almost_full), 32'd0);
                if (n_acc == 4) chk("fill_af_at4", 32'(almost_full), 32'd1);
                if (n_acc == 6) chk("fill_s_ready_drop", 32'(s_ready), 32'd0);
                w++;
            end
        end
        chk("fill_accepted", 32'(n_acc), 32'd6);
        chk("fill_cnt", 32'(cnt), 32'd6);
        chk("fill_af", 32'(almost_full), 32'd1);
        chk("fill_s_ready", 32'(s_ready), 32'd0);

        // 4: drain after fill, 0x07 and 0x08 still pending upstream
        rd_log.delete();
        rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = 8'(w); s_valid = (w <= 8);
            cycle(acc);
            if (i == 0) chk("drain_s_ready_c1", 32'(s_ready), 32'd0);
            if (i == 1) chk("drain_s_ready_c2", 32'(s_ready), 32'd1);
            if (acc) w++;
        end
        rd_en = 1'b0; s_valid = 1'b0;
        chk("drain_reads", 32'(rd_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < rd_log.size(); i++) begin
            chk("drain_seq", 32'(rd_log[i]), 32'(i + 1));
        end
        chk("drain_cnt", 32'(cnt), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);

        // 5: simultaneous accept and read at cnt=3, then read while empty
        for (int i = 0; i < 3; i++) begin
            s_data = 8'(8'h31 + i); s_valid = 1'b1;
            cycle(acc);
        end
        s_valid = 1'b0;
        repeat (2) cycle(acc);
        chk("sim_cnt3", 32'(cnt), 32'd3);
        chk("sim_empty", 32'(empty), 32'd0);
        s_data = 8'h34; s_valid = 1'b1; rd_en = 1'b1;
        cycle(acc);
        chk("sim_both_cnt", 32'(cnt), 32'd3);
        chk("sim_both_dout", 32'(dout), 32'h31);
        s_valid = 1'b0;
        repeat (8) cycle(acc);
        chk("sim_drained_cnt", 32'(cnt), 32'd0);
        chk("sim_drained_empty", 32'(empty), 32'd1);
        chk("sim_last", 32'(dout), 32'h34);
        cycle(acc);
        chk("empty_rd_cnt", 32'(cnt), 32'd0);
        chk("empty_rd_dout", 32'(dout), 32'h34);
        rd_en = 1'b0;

        // 6: random traffic against the reference queue
        s_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!s_valid || acc) s_data = 8'($urandom_range(0, 255));
            s_valid = ($urandom_range(0, 3) != 0);
            rd_en = ($urandom_range(0, 1) != 0);
            cycle(acc);
        end
        s_valid = 1'b0; rd_en = 1'b1;
        repeat (12) cycle(acc);
        rd_en = 1'b0;
        chk("rand_final_cnt", 32'(cnt), 32'd0);
        chk("rand_final_empty", 32'(empty), 32'd1);
        chk("rand_final_model", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_stream_wr.md
Name: fifo_stream_wr

Overview:
- Write-side counterpart to the FWFT read adapter. Accepts a valid/ready upstream stream and buffers it through a registered 2-entry skid stage into an internal standard synchronous fifo.
- Upstream ready is registered, with no combinational path from fifo full to s_ready.
- Read side keeps standard fifo semantics: rd_en, with data one cycle later. Sits between a stream producer and any standard-fifo consumer.

Parameters:
- DATA_WIDTH, 8, width of s_data/dout.
- DEPTH_WIDTH, 2, log2 of internal fifo depth (2^DEPTH_WIDTH entries).
- ALMOST_FULL_THRESH, 4, cnt value at or above which almost_full asserts.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- s_data  in  DATA_WIDTH  upstream data.
- s_valid  in  1  upstream data valid.
- s_ready  out  1  block can accept; registered.
- rd_en  in  1  read request, standard fifo semantics.
- dout  out  DATA_WIDTH  read data, valid the cycle after rd_en && !empty.
- empty  out  1  internal fifo empty (from fifo0 empty_o).
- almost_full  out  1  cnt >= ALMOST_FULL_THRESH; combinational from cnt register.
- cnt  out  DEPTH_WIDTH+2  total words held (fifo + stage + skid).

Behaviour:
- Reset (async, active-high): out_valid=0, skid_valid=0, out_data=0, skid_data=0, cnt=0, s_ready=1, almost_full=0. The internal fifo also receives rst and is empty after reset. Reset mid-operation discards all held words; no partial write occurs.
- accept = s_valid && s_ready.
- drain = out_valid && !fifo_full. drain drives fifo wr_en; out_data drives wr_data.
- s_ready = !skid_valid.
- Per clock edge, priority order:
  - (a) If !out_valid or drain:
    - If skid_valid: out_data<=skid_data, out_valid<=1, skid_valid<=0.
    - Else if accept: out_data<=s_data, out_valid<=1.
    - Else: out_valid<=0.
  - (b) Otherwise (out stalled): if accept then skid_data<=s_data, skid_valid<=1.
- Word ordering is strictly preserved: skid always drains before new input. No word is dropped or duplicated.
- Latency:
  - Word accepted at edge N is written into the fifo at edge N+1 if the fifo is not full.
  - empty deasserts after edge N+1.
  - With continuous s_valid and no backpressure, throughput is 1 word/clk.
- Backpressure:
  - When the fifo is full, out holds.
  - The next accepted word goes to skid, then s_ready drops at the following edge.
  - Maximum held = 2^DEPTH_WIDTH + 2.
- Reads: rd_en with empty=1 is ignored (no cnt change, dout holds).
- cnt:
  - +1 on accept only; -1 on (rd_en && !empty) only; unchanged when both or neither.
  - Never wraps: max is 2^DEPTH_WIDTH+2 and min is 0.
  - Width DEPTH_WIDTH+2.
- Simultaneous fifo write and read in the same cycle are both honoured. Full/empty behaviour is per fifo0.

Decomposition:
- No package needed; parameters are local.
- One sub-module: existing fifo (instance fifo0, ports clk, rst, wr_en_i, wr_data_i, full_o, rd_en_i, rd_data_o, empty_o).
- Skid stage and cnt logic live in fifo_stream_wr.

Test Plan (DATA_WIDTH=8, DEPTH_WIDTH=2, THRESH=4):
1. Reset then idle.
   - Stimulus: reset, then idle.
   - Required response: s_ready=1, empty=1, cnt=0, almost_full=0. Assert rst asynchronously mid-cycle; outputs clear before the next edge.
2. Single word.
   - Stimulus: s_data=0xA5 accepted at edge N.
   - Required response: empty=0 after N+1. Pulse rd_en; dout=0xA5 next cycle, cnt 1->0, empty=1.
3. Fill with backpressure.
   - Stimulus: stream 0x01..0x08 with rd_en=0.
   - Required response: exactly 6 accepted (0x01..0x06). s_ready=0 from the edge after 0x06 is taken. cnt=6, almost_full=1 from cnt=4.
4. Drain after fill.
   - Stimulus: from the state in 3, hold rd_en=1.
   - Required response: dout sequence 0x01..0x06 in order. s_ready reasserts once skid drains. Remaining 0x07, 0x08 are accepted and read out after 0x06. cnt returns to 0.
5. Simultaneous accept and read at cnt=3.
   - Required response: cnt stays 3. rd_en while empty=1 leaves cnt=0 and dout unchanged.
6. Random valid/rd_en, 1000 cycles, against a reference queue.
   - Required response: in-order, no loss or duplication. cnt always equals model occupancy and stays <=6.
